// File: rtl/mem_lsu_stage.sv
// MEM-stage load/store unit: runs one req/ack data-bus transaction per access and
// formats load data for MEM/WB. Optional bus timeout enabled by `define LSU_TIMEOUT_EN.
module mem_lsu_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_mem_rden,
  input  logic        i_mem_wren,
  input  logic [3:0]  i_byte_num,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_data,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, ld_data_q, ld_data_d;
  logic [3:0]  be_q;
  logic        we_q, uns_q;
  logic [1:0]  off_q, size_q, size_in;
  logic        is_word, is_half, misalign_raw, mem_op, access;
  logic [31:0] wdata_rep, ld_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ext;
  logic        latch, timeout;

  assign is_word      = i_byte_num[3];
  assign is_half      = ~i_byte_num[3] & i_byte_num[1];
  assign misalign_raw = (is_word & (i_addr[1:0] != 2'b00)) | (is_half & i_addr[0]);
  assign mem_op       = i_valid & (i_mem_rden | i_mem_wren);
  assign access       = mem_op & ~misalign_raw;
  assign size_in      = is_word ? SizeWord : (is_half ? SizeHalf : SizeByte);

  always_comb begin
    wdata_rep = i_wdata;
    if (is_half) begin
      wdata_rep = {2{i_wdata[15:0]}};
    end else if (!is_word) begin
      wdata_rep = {4{i_wdata[7:0]}};
    end
  end

  // Load formatting uses the offset/size captured at accept, not the live inputs.
  assign ld_byte = i_bus_rdata[8*off_q +: 8];
  assign ld_half = i_bus_rdata[16*off_q[1] +: 16];

  always_comb begin
    ext    = 1'b0;
    ld_fmt = i_bus_rdata;
    if (size_q == SizeHalf) begin
      ext    = ~uns_q & ld_half[15];
      ld_fmt = {{16{ext}}, ld_half};
    end else if (size_q == SizeByte) begin
      ext    = ~uns_q & ld_byte[7];
      ld_fmt = {{24{ext}}, ld_byte};
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_data_d = ld_data_q;
    latch     = 1'b0;
    o_stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          latch   = 1'b1;
          o_stall = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        o_stall = 1'b1;
        if (i_bus_ack) begin
          if (!we_q) ld_data_d = ld_fmt;
          state_d = StDone;
        end else if (timeout) begin
          if (!we_q) ld_data_d = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Keep the pipeline free while reset is held, whatever the inputs show.
    o_stall = o_stall & i_rst_n;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      size_q    <= SizeByte;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_data_q <= ld_data_d;
      if (latch) begin
        addr_q  <= {i_addr[31:2], 2'b00};
        wdata_q <= wdata_rep;
        be_q    <= i_byte_num << i_addr[1:0];
        we_q    <= i_mem_wren;
        uns_q   <= i_ld_unsigned;
        off_q   <= i_addr[1:0];
        size_q  <= size_in;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = 16;

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == StBusy) & ~i_bus_ack & timeout;
      if (latch) begin
        cnt_q <= '0;
      end else if ((state_q == StBusy) && !i_bus_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_bus_err = err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  assign o_bus_req   = (state_q == StBusy);
  assign o_bus_we    = (state_q == StBusy) & we_q;
  assign o_bus_be    = (state_q == StBusy) ? be_q : 4'b0000;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_ld_data   = ld_data_q;
  assign o_misalign  = (state_q == StIdle) & mem_op & misalign_raw;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Self-checking bench for mem_lsu_stage: directed scenarios plus randomized accesses
// checked against an arithmetic reference of the load/store rules.
module tb_mem_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, mem_rden, mem_wren, ld_unsigned, bus_ack;
  logic [3:0]  byte_num;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic        stall, misalign, bus_req, bus_we, bus_err;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] ld_model;

  always #5 clk = ~clk;

  mem_lsu_stage #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_mem_rden   (mem_rden),
    .i_mem_wren   (mem_wren),
    .i_byte_num   (byte_num),
    .i_ld_unsigned(ld_unsigned),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_ld_data    (ld_data),
    .o_stall      (stall),
    .o_misalign   (misalign),
    .o_bus_req    (bus_req),
    .o_bus_we     (bus_we),
    .o_bus_addr   (bus_addr),
    .o_bus_be     (bus_be),
    .o_bus_wdata  (bus_wdata),
    .i_bus_ack    (bus_ack),
    .i_bus_rdata  (bus_rdata),
    .o_bus_err    (bus_err)
  );

  function automatic logic is_mis(input logic [3:0] bn, input logic [31:0] a);
    if (bn == 4'b1111) return (a % 4) != 0;
    if (bn == 4'b0011) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] bn, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    int unsigned off;
    logic [31:0] v;
    off = a % 4;
    if (bn == 4'b1111) return rd;
    if (bn == 4'b0011) begin
      v = (rd >> (16 * (off / 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = (rd >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] bn, input logic [31:0] wd);
    if (bn == 4'b1111) return wd;
    if (bn == 4'b0011) return (wd % 65536) * 32'h00010001;
    return (wd % 256) * 32'h01010101;
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] bn, input logic [31:0] a);
    logic [31:0] v;
    v = (32'(bn) << (a % 4)) % 16;
    return v[3:0];
  endfunction

  // Drives one instruction until the unit releases it; ack arrives after `waits` wait states.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [3:0] bn, input logic uns, input logic [31:0] a,
                            input logic [31:0] wd, input int waits, input logic [31:0] rdata);
    int stalls;
    int busy;
    logic done;
    logic mis;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    stalls = 0;
    busy   = 0;
    done   = 1'b0;
    mis    = is_mis(bn, a);
    e_addr = a & 32'hFFFFFFFC;
    e_wd   = exp_wdata(bn, wd);
    e_be   = exp_be(bn, a);
    @(negedge clk);
    valid = 1'b1; mem_rden = rd; mem_wren = wr; byte_num = bn; ld_unsigned = uns;
    addr = a; wdata = wd; bus_ack = 1'b0; bus_rdata = $urandom;
    if (!(rd | wr) || mis) begin
      #1;
      checks++;
      if (misalign !== ((rd | wr) && mis)) begin
        errors++;
        $display("FAIL %s misalign: got %b exp %b", name, misalign, (rd | wr) && mis);
      end
      checks++;
      if (stall !== 1'b0 || bus_req !== 1'b0) begin
        errors++;
        $display("FAIL %s no_access: stall=%b req=%b exp 0 0", name, stall, bus_req);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus_req !== 1'b0 || ld_data !== ld_model) begin
        errors++;
        $display("FAIL %s no_access_hold: req=%b ld=%h exp 0 %h", name, bus_req, ld_data,
                 ld_model);
      end
      valid = 1'b0;
      return;
    end
    if (rd && !wr) ld_model = exp_load(bn, uns, a, rdata);
    for (int cyc = 0; cyc < waits + 8 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (cyc == 0) begin
        stalls++;
        checks++;
        if (stall !== 1'b1 || bus_req !== 1'b0 || misalign !== 1'b0) begin
          errors++;
          $display("FAIL %s accept: stall=%b req=%b mis=%b exp 1 0 0", name, stall, bus_req,
                   misalign);
        end
      end else if (!stall) begin
        done    = 1'b1;
        bus_ack = 1'b0;
        checks++;
        if (ld_data !== ld_model) begin
          errors++;
          $display("FAIL %s ld_data: got %h exp %h", name, ld_data, ld_model);
        end
        checks++;
        if (bus_req !== 1'b0 || bus_be !== 4'b0 || bus_we !== 1'b0) begin
          errors++;
          $display("FAIL %s done_bus: req=%b be=%b we=%b exp 0", name, bus_req, bus_be, bus_we);
        end
      end else begin
        stalls++;
        if (bus_req) begin
          busy++;
          checks++;
          if (bus_addr !== e_addr || bus_be !== e_be || bus_we !== wr || bus_wdata !== e_wd) begin
            errors++;
            $display("FAIL %s bus: addr=%h be=%b we=%b wd=%h exp %h %b %b %h", name, bus_addr,
                     bus_be, bus_we, bus_wdata, e_addr, e_be, wr, e_wd);
          end
          if (busy == waits + 1) begin
            bus_ack = 1'b1;
            bus_rdata = rdata;
          end else begin
            bus_ack = 1'b0;
            bus_rdata = $urandom;
          end
        end else begin
          bus_ack = 1'b0;
        end
      end
    end
    bus_ack = 1'b0;
    valid   = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s release: stall never dropped within %0d cycles", name, waits + 8);
    end else if (stalls != waits + 2) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d exp %0d", name, stalls, waits + 2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; mem_rden = 1'b1; mem_wren = 1'b0; byte_num = 4'hF;
    ld_unsigned = 1'b0; addr = 32'h40; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    ld_model = 32'h0;
    #12;
    checks++;
    if ({ld_data, bus_addr, bus_wdata} !== 96'h0 || {stall, bus_req, bus_we, bus_err} !== 4'h0
        || bus_be !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: ld=%h addr=%h wd=%h st=%b req=%b we=%b err=%b be=%b exp 0",
               ld_data, bus_addr, bus_wdata, stall, bus_req, bus_we, bus_err, bus_be);
    end
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    run_access("word_load", 1'b1, 1'b0, 4'b1111, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
  endtask

  task automatic test_byte_load();
    run_access("byte_load_s", 1'b1, 1'b0, 4'b0001, 1'b0, 32'h103, 32'h0, 0, 32'h80112233);
    checks++;
    if (ld_data !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL byte_load_s const: got %h exp ffffff80", ld_data);
    end
    run_access("byte_load_u", 1'b1, 1'b0, 4'b0001, 1'b1, 32'h103, 32'h0, 1, 32'h80112233);
    checks++;
    if (ld_data !== 32'h00000080) begin
      errors++;
      $display("FAIL byte_load_u const: got %h exp 00000080", ld_data);
    end
  endtask

  task automatic test_half_store();
    run_access("half_store", 1'b0, 1'b1, 4'b0011, 1'b0, 32'h202, 32'h1234ABCD, 3, 32'h5555AAAA);
    checks++;
    if (bus_wdata !== 32'hABCDABCD) begin
      errors++;
      $display("FAIL half_store wdata_hold: got %h exp abcdabcd", bus_wdata);
    end
  endtask

  task automatic test_misalign();
    run_access("mis_word", 1'b1, 1'b0, 4'b1111, 1'b0, 32'h101, 32'h0, 0, 32'h0);
    run_access("mis_half", 1'b0, 1'b1, 4'b0011, 1'b0, 32'h203, 32'h1, 0, 32'h0);
    @(negedge clk);
    valid = 1'b0; mem_rden = 1'b1; byte_num = 4'b1111; addr = 32'h101;
    #1;
    checks++;
    if (misalign !== 1'b0) begin
      errors++;
      $display("FAIL mis_invalid: got %b exp 0", misalign);
    end
  endtask

  task automatic test_ack_idle();
    @(negedge clk);
    valid = 1'b0; bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_rdata = $urandom;
      @(negedge clk);
      #1;
      checks++;
      if (ld_data !== ld_model || bus_req !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL ack_idle: ld=%h req=%b st=%b exp %h 0 0", ld_data, bus_req, stall,
                 ld_model);
      end
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    valid = 1'b1; mem_rden = 1'b1; mem_wren = 1'b0; byte_num = 4'b1111; ld_unsigned = 1'b0;
    addr = 32'h300; bus_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_pre: req=%b exp 1", bus_req);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    ld_model = 32'h0;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || bus_addr !== 32'h0 || ld_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: req=%b st=%b addr=%h ld=%h exp 0", bus_req, stall, bus_addr,
               ld_data);
    end
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ld_data !== 32'h0 || bus_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_late_ack: ld=%h req=%b exp 0 0", ld_data, bus_req);
      end
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_access("b2b", (i % 2) == 0, (i % 2) == 1, 4'b1111, 1'b0, 32'h400 + 32'(4 * i),
                 $urandom, 0, $urandom);
    end
  endtask

  task automatic test_random();
    logic [3:0] bn;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       bn = 4'b0001;
        1:       bn = 4'b0011;
        default: bn = 4'b1111;
      endcase
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = (bn == 4'b1111) ? (a & ~32'h3) :
                                         ((bn == 4'b0011) ? (a & ~32'h1) : a);
      run_access("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bn,
                 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), $urandom);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int busy;
    int errs;
    logic done;
    logic [31:0] ld_at_err;
    busy = 0; errs = 0; done = 1'b0; ld_at_err = 32'hFFFFFFFF;
    run_access("pre_timeout", 1'b1, 1'b0, 4'b1111, 1'b0, 32'h500, 32'h0, 0, 32'h12345678);
    @(negedge clk);
    valid = 1'b1; mem_rden = 1'b1; mem_wren = 1'b0; byte_num = 4'b1111; addr = 32'h504;
    bus_ack = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (bus_req) busy++;
      if (bus_err) begin
        errs++;
        ld_at_err = ld_data;
      end
      if (cyc > 0 && !stall) done = 1'b1;
    end
    valid = 1'b0;
    ld_model = 32'h0;
    checks++;
    if (!done || busy != 4 || errs != 1) begin
      errors++;
      $display("FAIL timeout: done=%b busy=%0d err_pulses=%0d exp 1 4 1", done, busy, errs);
    end
    checks++;
    if (ld_at_err !== 32'h0) begin
      errors++;
      $display("FAIL timeout_ld: got %h exp 0", ld_at_err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus_err !== 1'b0 || bus_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: err=%b req=%b st=%b exp 0 0 0", bus_err, bus_req, stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_ack_idle();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- Load/store unit of the MEM stage. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the EX/MEM memory controls and datapath fields: mem_wren, a load indication, byte_num, ld_unsigned, alu_data as the address, and rs2_forward as the store data.
- Runs a req/ack transaction on the data-memory bus and produces the extended ld_data that the MEM/WB register captures.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort. Used only with LSU_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  EX/MEM slot holds a valid instruction.
- i_mem_rden  in  1  instruction is a load (wb_sel = load).
- i_mem_wren  in  1  instruction is a store.
- i_byte_num  in  4  access size mask: 0001 byte, 0011 half, 1111 word (unshifted).
- i_ld_unsigned  in  1  zero-extend the load when 1, sign-extend when 0.
- i_addr  in  32  byte address (alu_data).
- i_wdata  in  32  store data (rs2_forward).
- o_ld_data  out  32  extended load data for MEM/WB.
- o_stall  out  1  hold IF..EX/MEM this cycle.
- o_misalign  out  1  misaligned access detected (combinational).
- o_bus_req  out  1  bus request.
- o_bus_we  out  1  bus write.
- o_bus_addr  out  32  word-aligned address ({i_addr[31:2],2'b00} registered).
- o_bus_be  out  4  byte enables.
- o_bus_wdata  out  32  lane-replicated store data.
- i_bus_ack  in  1  bus completes the transaction this cycle.
- i_bus_rdata  in  32  read word, valid when i_bus_ack=1.
- o_bus_err  out  1  timeout abort pulse (only with LSU_TIMEOUT_EN; otherwise tied 0).

Behaviour:
- Access condition: access = i_valid & (i_mem_rden | i_mem_wren) & ~misalign. If both rden and wren are set, wren wins.
- Misalignment rules:
  - Half access with i_addr[0]=1 is misaligned.
  - Word access with i_addr[1:0]≠00 is misaligned.
  - Byte access is never misaligned.
- Byte enables: o_bus_be = i_byte_num << i_addr[1:0], registered on accept.
- Store data lane replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with access: latch addr/be/wdata/we/ld_unsigned/offset, o_stall=1, go to BUSY.
  - IDLE, no access: o_stall=0, stay in IDLE.
  - IDLE with misalign and i_valid and (rden|wren): o_misalign=1, no bus activity, o_stall=0, o_ld_data unchanged.
  - BUSY: o_bus_req=1 with stable addr/be/wdata/we.
    - i_bus_ack=0: o_stall=1, stay.
    - i_bus_ack=1: o_stall=0 is not allowed here; o_stall stays 1. On a load, register the formatted rdata into o_ld_data. Go to DONE.
  - DONE: o_stall=0, o_bus_req=0. The instruction still presented is the serviced one and is not re-issued. Go to IDLE unconditionally.
- Occupancy: zero-wait ack gives 2 stall cycles, then DONE (3 cycles total per access). Each wait state adds 1.
- Load format uses the latched offset:
  - byte: rdata[8*off+:8], extended.
  - half: rdata[16*off[1]+:16], extended.
  - word: rdata unchanged.
  - Extension is 0 when ld_unsigned=1, otherwise the sign bit.
- Stores leave o_ld_data unchanged.
- o_bus_req, o_bus_we, o_bus_be are 0 outside BUSY. o_bus_addr and o_bus_wdata hold their last latched values.
- Reset (any time, including mid-BUSY), asynchronous:
  - State returns to IDLE.
  - o_bus_req=0, o_bus_we=0, o_bus_be=0, o_bus_addr=0, o_bus_wdata=0, o_ld_data=0, o_stall=0, o_bus_err=0.
  - An outstanding transaction is abandoned. An ack arriving after reset is ignored.
- i_bus_ack outside BUSY is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack: drop o_bus_req, pulse o_bus_err=1 for one cycle, force o_ld_data=0 on a load, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- Undefined: no counter. BUSY waits indefinitely. o_bus_err is constant 0.

Test Plan:
- Word load, addr=0x100, rdata=0xDEADBEEF, ack in first BUSY cycle -> be=1111, addr 0x100, o_stall high 2 cycles, o_ld_data=0xDEADBEEF in DONE.
- Signed byte load addr=0x103, rdata=0x80112233 -> be=1000, o_ld_data=0xFFFFFF80. Same with ld_unsigned=1 -> 0x00000080.
- Half store addr=0x202, wdata=0x1234ABCD, ack after 3 wait cycles -> be=1100, o_bus_wdata=0xABCDABCD, we=1, o_stall high 5 cycles, o_ld_data unchanged.
- Word load addr=0x101 -> o_misalign=1, o_bus_req stays 0, o_stall=0.
- Reset asserted mid-BUSY -> o_bus_req=0 immediately (asynchronous). After release, a late ack produces no o_ld_data change.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> o_bus_err pulses after 4 BUSY cycles, o_ld_data=0, return to IDLE via DONE.
